// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key constants and keymap for the keypad link.
package keypad_pkg;

    typedef enum logic [2:0] {SCAN, DEBOUNCE, SETUP, STROBE, WAIT_RELEASE} tx_state_t;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    // Indexed by {row, col}; '*' encodes as ENTER and '#' as CLEAR.
    localparam logic [0:15][3:0] KEY_TABLE = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        KEY_ENTER, 4'h0, KEY_CLEAR, 4'hD
    };

    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        return KEY_TABLE[{row, col}];
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_tx_if.sv
// keypad_tx_if: encoded key link from the keypad transmitter to the lock receiver.
interface keypad_tx_if;
    logic [3:0] key_code;
    logic       key_validn;
    logic       busy;
    modport master(output key_code, key_validn, busy);
    modport slave (input  key_code, key_validn, busy);
endinterface

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 4-bit two-flop synchronizer for active-low keypad rows, idles high.
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q, sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_tx.sv
// keypad_tx: scans a 4x4 keypad, debounces one key and strobes its code on the link.
// Define KEYPAD_TX_REPEAT_EN to re-strobe a key held for REPEAT_SCANS samples.
module keypad_tx
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 10,
    parameter int SETUP_CYCLES   = 4,
    parameter int STROBE_CYCLES  = 16
`ifdef KEYPAD_TX_REPEAT_EN
    ,
    parameter int REPEAT_SCANS   = 500
`endif
) (
    input  logic             MAX10_CLK1_50,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    keypad_tx_if.master      link
);

    localparam int SW   = $clog2(SCAN_DIV);
    localparam int DW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int CMAX = SETUP_CYCLES > STROBE_CYCLES ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    tx_state_t     state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0] cyc_q, cyc_d, cyc_inc;
    logic [3:0]    code_q, code_d;
    logic [3:0]    rows;
    logic          slot_end, any_low, same_key, released, cnt_last, rep_fire;

    keypad_row_sync u_sync (
        .clk(MAX10_CLK1_50),
        .rst(reset),
        .d  (row_in),
        .q  (rows)
    );

    // Rows are only acted on at the last clock of each column slot.
    assign slot_end = slot_q == SW'(SCAN_DIV - 1);
    assign slot_d   = slot_end ? '0 : slot_q + 1'b1;
    assign any_low  = ~&rows;
    assign same_key = any_low && lowest_low(rows) == row_q;
    assign released = rows[row_q];
    assign cnt_last = cnt_q == DW'(DEBOUNCE_SCANS - 1);
    assign cnt_inc  = cnt_q == DW'(DEBOUNCE_SCANS) ? cnt_q : cnt_q + 1'b1;
    assign cyc_inc  = cyc_q == CW'(CMAX) ? cyc_q : cyc_q + 1'b1;

`ifdef KEYPAD_TX_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_q, rep_d;
    assign rep_fire = state_q == WAIT_RELEASE && slot_end && !released &&
                      rep_q == RW'(REPEAT_SCANS - 1);
    assign rep_d = state_q != WAIT_RELEASE ? '0 :
                   !slot_end               ? rep_q :
                   released || rep_fire    ? '0 :
                   rep_q == RW'(REPEAT_SCANS) ? rep_q : rep_q + 1'b1;
    always_ff @(posedge MAX10_CLK1_50) rep_q <= reset ? '0 : rep_d;
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        cyc_d   = '0;
        code_d  = code_q;
        case (state_q)
            SCAN: if (slot_end) begin
                if (any_low) begin
                    row_d   = lowest_low(rows);
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DEBOUNCE: if (slot_end) begin
                if (!same_key) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else if (cnt_last) begin
                    cnt_d   = '0;
                    code_d  = keymap(row_q, col_q);
                    state_d = SETUP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SETUP: begin
                cyc_d = cyc_inc;
                if (cyc_q == CW'(SETUP_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                cyc_d = cyc_inc;
                if (cyc_q == CW'(STROBE_CYCLES - 1)) begin
                    cyc_d   = '0;
                    cnt_d   = '0;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: if (slot_end) begin
                if (!released) begin
                    cnt_d   = '0;
                    state_d = rep_fire ? SETUP : WAIT_RELEASE;
                end else if (cnt_last) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q <= SCAN;
            slot_q  <= '0;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            code_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            code_q  <= code_d;
        end
    end

    // Strobe and busy decode straight from the state register so reset drops them at once.
    assign col_out         = ~(4'b0001 << col_q);
    assign link.key_code   = code_q;
    assign link.key_validn = state_q != STROBE;
    assign link.busy       = state_q inside {SETUP, STROBE, WAIT_RELEASE};

endmodule

// File: doc/keypad_tx.md
Name: keypad_tx

Overview:
Transmit end of the keypad-to-FPGA link. Scans a 4x4 active-low matrix keypad, debounces one key, encodes it to a 4-bit code, and presents it as key_code[3:0] with an active-low strobe key_validn. These are the signals the combo lock receives on ARDUINO_IO[11:8] and ARDUINO_IO[12]. Runs on the keypad-side board, or on the same FPGA for loopback.

Parameters:
SCAN_DIV, 50000, clocks per column slot (1 ms at 50 MHz); minimum 4
DEBOUNCE_SCANS, 10, consecutive matching row samples needed to accept a press or a release
SETUP_CYCLES, 4, clocks key_code is stable with key_validn high before the strobe
STROBE_CYCLES, 16, clocks key_validn is held low; minimum 4, so the receiver's 2-flop sync and low-count sampler sees it

Ports:
MAX10_CLK1_50  input   1  system clock
reset          input   1  synchronous, active-high reset
row_in         input   4  keypad rows, active low, externally pulled up, asynchronous
col_out        output  4  keypad column drive, active low, exactly one bit low at a time
key_code       output  4  encoded key value
key_validn     output  1  active-low strobe; key_code is valid while low
busy           output  1  high from accepted press until release is confirmed

Behaviour:
- Reset values: col_out=4'b1110, key_code=4'h0, key_validn=1, busy=0, FSM=SCAN, all counters 0.
- row_in passes through a 2-flop synchronizer. The row sample is the synchronized value on the last clock of each column slot.
- Keymap (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: *=E 0 #=F D
  - E is ENTER and F is CLEAR, as decoded by the lock.
- FSM states:
  - SCAN: rotate the low column 0->1->2->3->0 every SCAN_DIV clocks. If a sample shows any row low, latch the column and the lowest-index low row (lowest row wins on multiple keys), then go to DEBOUNCE with the column frozen.
  - DEBOUNCE: each slot, sample the same column. If the latched row is still the lowest low row, increment the count; otherwise clear it and return to SCAN, resuming at the next column. When the count reaches DEBOUNCE_SCANS, register key_code=keymap(row,col), set busy=1, go to SETUP.
  - SETUP: hold key_validn=1 for SETUP_CYCLES clocks, then go to STROBE.
  - STROBE: key_validn=0 for exactly STROBE_CYCLES clocks, then key_validn=1 and go to WAIT_RELEASE.
  - WAIT_RELEASE: column stays frozen. Require DEBOUNCE_SCANS consecutive samples with the latched row high, then set busy=0 and go to SCAN. A bounce resets the count.
- key_code changes only on entry to SETUP and is held through STROBE and WAIT_RELEASE. It is never changed while key_validn is low.
- Exactly one strobe per press. A second key pressed while busy is ignored until the first is released and scanning resumes.
- Latency from a stable press at the pins to the key_validn falling edge is at most 2 + 4*SCAN_DIV + DEBOUNCE_SCANS*SCAN_DIV + SETUP_CYCLES clocks.
- Reset asserted in any state forces the reset values on the next clock. An in-flight strobe is cut short and key_validn goes high immediately.
- The slot counter width is $clog2(SCAN_DIV). Other counters are sized from their parameters. Counters saturate and never wrap.

Optional Feature:
KEYPAD_TX_REPEAT_EN
- Defined: adds parameter REPEAT_SCANS (default 500). In WAIT_RELEASE, if the key stays pressed for REPEAT_SCANS consecutive samples, return to SETUP and re-emit the same key_code as a new strobe, then restart the count. Release behaves as in the base design.
- Undefined: no repeat logic is compiled. One strobe per press.

Decomposition:
- Package keypad_pkg holds:
  - typedef enum logic [2:0] tx_state_t {SCAN, DEBOUNCE, SETUP, STROBE, WAIT_RELEASE}
  - constants KEY_ENTER=4'hE and KEY_CLEAR=4'hF
  - function keymap(row, col) returning logic [3:0]
- Sub-module keypad_row_sync: 4-bit 2-flop synchronizer with reset to 4'hF. It is instantiated once, and the lock side can reuse it.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, SETUP_CYCLES=2, STROBE_CYCLES=8):
1. Reset, no keys pressed -> col_out cycles 1110, 1101, 1011, 0111 every 4 clocks; key_validn stays 1; busy=0.
2. Hold row1/col2 low cleanly -> key_code=4'h6; key_validn low for exactly 8 clocks after 2 setup clocks; busy falls only after 3 release samples.
3. Press row3/col0 (*) then row3/col2 (#) -> two strobes with codes 4'hE then 4'hF. A looped-back combo lock in enter_pw with index 6 saves on E and returns index 0 on F.
4. Bounce row0/col0 for 2 samples, then release -> no strobe; FSM back in SCAN; key_code unchanged.
5. Hold row0/col1 and row2/col1 together -> single strobe with 4'h2 (lowest row). Pressing row2/col3 while busy -> no strobe.
6. Assert reset 3 clocks into STROBE -> key_validn=1 and col_out=4'b1110 on the next clock. With KEYPAD_TX_REPEAT_EN, holding a key beyond REPEAT_SCANS -> a second identical strobe.
